// File: rtl/frame_payload_capture.sv
// frame_payload_capture: after each sync from the 1011 detector, deserialises the
// next PAYLOAD_BITS serial bits MSB-first and offers the word on a valid/ready
// output register. Counts delivered frames and flags a sticky overrun on drops.
module frame_payload_capture #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned COUNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    data_in,
  input  logic                    sync_detected,
  input  logic                    clear_overrun,
  output logic [PAYLOAD_BITS-1:0] payload_out,
  output logic                    payload_valid,
  input  logic                    payload_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [COUNT_W-1:0]      frame_count
);

  // Bit counter only needs to reach PAYLOAD_BITS-1.
  localparam int unsigned CNT_W = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BITS - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CAPTURE = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic [PAYLOAD_BITS-1:0] word;

  // Next-state logic for capture FSM, output register and status.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    count_d   = count_q;
    // Shift register contents with the current bit appended at the LSB.
    word      = {shift_q[PAYLOAD_BITS-2:0], data_in};

    // Transfer empties the register; a load below may refill it on the same edge.
    if (valid_q && payload_ready) begin
      valid_d = 1'b0;
    end
    // Clear first so that a drop on the same edge wins.
    if (clear_overrun) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable && sync_detected) begin
          // Bit present during the sync cycle is payload bit 0.
          shift_d = word;
          cnt_d   = CNT_W'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end else if (cnt_q < LAST_CNT) begin
          shift_d = word;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = word;
          if (!valid_q || payload_ready) begin
            payload_d = word;
            valid_d   = 1'b1;
            count_d   = count_q + COUNT_W'(1);
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      count_q   <= count_d;
    end
  end

  assign payload_out   = payload_q;
  assign payload_valid = valid_q;
  assign overrun       = ovr_q;
  assign frame_count   = count_q;
  assign busy          = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_payload_capture.sv
// Scoreboarded bench for frame_payload_capture: directed scenarios followed by
// randomized per-cycle stimulus, checked against a frame-level reference model.
module tb_frame_payload_capture;

  localparam int unsigned PB = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          data_in = 1'b0;
  logic          sync_detected = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [PB-1:0] payload_out;
  logic          payload_valid;
  logic          payload_ready = 1'b0;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] frame_count;

  frame_payload_capture #(
    .PAYLOAD_BITS (PB),
    .COUNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .data_in       (data_in),
    .sync_detected (sync_detected),
    .clear_overrun (clear_overrun),
    .payload_out   (payload_out),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .busy          (busy),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a frame collector plus a one-entry output buffer.
  int unsigned exp_q[$];
  bit          m_cap;
  int          m_nbits;
  int unsigned m_word;
  bit          m_occ;
  bit          m_ovr;
  int unsigned m_cnt;
  int unsigned m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cap = 0; m_nbits = 0; m_word = 0; m_occ = 0; m_ovr = 0; m_cnt = 0; m_last = 0;
    exp_q.delete();
  endtask

  // Apply what the next rising edge does, given the inputs about to be sampled.
  task automatic model_edge(input bit s, input bit d, input bit e, input bit r, input bit c);
    bit xfer;
    bit loaded;
    xfer   = m_occ && r;
    loaded = 0;
    if (c) m_ovr = 0;
    if (!m_cap) begin
      if (e && s) begin
        m_cap = 1; m_nbits = 1; m_word = d;
      end
    end else if (!e) begin
      m_cap = 0;
    end else begin
      m_word = m_word * 2 + d;
      m_nbits++;
      if (m_nbits == PB) begin
        m_cap = 0;
        if (!m_occ || r) begin
          exp_q.push_back(m_word);
          m_last = m_word;
          m_cnt  = (m_cnt + 1) % (1 << CW);
          loaded = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end
    if (loaded) m_occ = 1;
    else if (xfer) m_occ = 0;
  endtask

  task automatic step(input bit s, input bit d, input bit e, input bit r, input bit c);
    sync_detected = s; data_in = d; enable = e; payload_ready = r; clear_overrun = c;
    model_edge(s, d, e, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(payload_valid), 32'(m_occ));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_count"}, 32'(frame_count), m_cnt);
    chk({tag, "_busy"}, 32'(busy), 32'(m_cap));
    chk({tag, "_payload"}, 32'(payload_out), m_last);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sync_detected = 0; data_in = 0; enable = 0; payload_ready = 0; clear_overrun = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Send one frame: sync with bit 7, then bits 6..0. Optional extra sync pulse
  // at bit index sync_at and enable drop at abort_at (frame then abandoned).
  task automatic send_frame(input logic [PB-1:0] w, input bit rdy, input bit rdy_last,
                            input int sync_at, input int abort_at);
    for (int i = 0; i < PB; i++) begin
      if (i == abort_at) begin
        step(1'b0, w[PB-1-i], 1'b0, rdy, 1'b0);
        return;
      end
      step((i == 0) || (i == sync_at), w[PB-1-i], 1'b1, (i == PB - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the edge following this sample.
  always @(negedge clk) begin
    if (!reset && payload_valid && payload_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_word: got 0x%0h expected no delivery at %0t", payload_out, $time);
      end else begin
        chk("sb_word", 32'(payload_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    // 1: reset state
    do_reset();
    chk("rst_valid", 32'(payload_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_payload", 32'(payload_out), 32'd0);

    // 2: basic frame A5, latency of 8 edges
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    chk("a5_payload", 32'(payload_out), 32'hA5);
    chk("a5_valid", 32'(payload_valid), 32'd1);
    chk("a5_count", 32'(frame_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("a5_valid_one_cycle", 32'(payload_valid), 32'd0);

    // 3: sync ignored mid-capture, then back-to-back frame
    send_frame(8'h5B, 1'b1, 1'b1, 5, -1);
    chk("5b_payload", 32'(payload_out), 32'h5B);
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    chk("3c_payload", 32'(payload_out), 32'h3C);
    chk("3c_count", 32'(frame_count), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 4: overrun with ready held low, then clear
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0, -1, -1);
    send_frame(8'h22, 1'b0, 1'b0, -1, -1);
    chk("ovr_payload", 32'(payload_out), 32'h11);
    chk("ovr_valid", 32'(payload_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(frame_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // 5: transfer and load on the same edge
    send_frame(8'h77, 1'b0, 1'b1, -1, -1);
    chk("same_edge_payload", 32'(payload_out), 32'h77);
    chk("same_edge_valid", 32'(payload_valid), 32'd1);
    chk("same_edge_overrun", 32'(overrun), 32'd0);
    chk("same_edge_count", 32'(frame_count), 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 6: enable drop aborts, then reset mid-capture with a word pending
    send_frame(8'hC3, 1'b1, 1'b1, -1, 3);
    chk("abort_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_valid", 32'(payload_valid), 32'd0);
    chk("abort_count", 32'(frame_count), 32'd2);
    send_frame(8'h99, 1'b0, 1'b0, -1, -1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    model_reset();
    #2;
    check_model("mid_reset");
    chk("mid_reset_payload_zero", 32'(payload_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;

    // Randomized per-cycle stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) == 0, 1'($urandom), ($urandom % 40) != 0,
           ($urandom % 10) < 6, ($urandom % 30) == 0);
      check_model("rnd");
    end

    // Drain: every loaded word must have been delivered
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(payload_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_payload_capture.md
Name: frame_payload_capture

Overview:
- Downstream consumer of the serial 1011 sync-pattern detector.
- Watches the same serial bit stream and the detector's Moore `sync_detected` flag.
- On each sync, deserialises the next PAYLOAD_BITS bits MSB-first into a word and presents it on a valid/ready output register.
- Counts delivered frames and flags overrun when a finished frame cannot be delivered.

Parameters:
PAYLOAD_BITS, 8, payload length in bits per frame; legal range 2..32.
COUNT_W, 8, width of frame_count; wraps modulo 2^COUNT_W.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
enable  input  1  when 0, no new capture starts and any capture in progress is aborted.
data_in  input  1  serial bit stream, same signal the detector samples.
sync_detected  input  1  detector Moore output; high for the cycle after the final pattern bit was sampled.
clear_overrun  input  1  synchronous clear of the sticky overrun flag.
payload_out  output  PAYLOAD_BITS  captured word, MSB = first bit after pattern.
payload_valid  output  1  payload_out holds an undelivered word.
payload_ready  input  1  consumer accepts payload_out when high together with payload_valid.
busy  output  1  high while in CAPTURE.
overrun  output  1  sticky; a completed frame was dropped.
frame_count  output  COUNT_W  number of frames loaded into the output register.

Behaviour:
- Reset (async): state=IDLE; shift register, bit counter, payload_out and frame_count = 0; payload_valid=0, overrun=0, busy=0.
- Alignment: the bit on data_in during the cycle `sync_detected` is high is payload bit 0, i.e. the first bit after the pattern.
- IDLE:
  - If enable & sync_detected at an edge: sample data_in into the shift register, set bit_cnt=1, go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE, each edge:
  - If enable=0: go to IDLE, discard partial word. No output, no count, no overrun.
  - Else if bit_cnt < PAYLOAD_BITS-1: shift data_in in at the LSB, bit_cnt++.
  - Else (last bit): form word = {shift[PAYLOAD_BITS-2:0], data_in} and go to IDLE.
    - If payload_valid=0 or payload_ready=1 this cycle: load word into payload_out, payload_valid=1, frame_count++.
    - Else: word dropped, payload_out unchanged, overrun=1.
  - sync_detected is ignored throughout CAPTURE, including the last-bit cycle; payload contents may contain 1011.
- Back-to-back frames: the cycle immediately after the last-bit edge is IDLE, so a sync in that cycle starts a new frame. There is no dead cycle.
- Latency: payload_valid rises on the edge that samples the last bit, PAYLOAD_BITS edges after the sync-cycle edge (inclusive of that edge).
- Output handshake:
  - payload_out and payload_valid hold steady while payload_valid=1 and payload_ready=0.
  - Transfer occurs on an edge with valid&ready. payload_valid clears on that edge unless a new word loads on the same edge.
  - If a new word loads on the same edge, payload_valid stays 1, payload_out takes the new word, and no overrun is flagged.
- overrun:
  - Set on a drop; cleared only by reset or by clear_overrun at an edge.
  - If clear_overrun and a new drop coincide, set wins.
- frame_count: increments only on a load into payload_out; wraps from 2^COUNT_W-1 to 0.
- busy = (state == CAPTURE).
- payload_out and payload_valid are registered; no combinational path from inputs to outputs.
- Reset mid-capture or with valid pending: everything returns to reset values immediately; the pending word is lost.

Test Plan:
1. Assert reset, then release with data idle → payload_valid=0, overrun=0, frame_count=0, busy=0, payload_out=0.
2. ready=1 held. Pulse sync_detected with data_in=1 that cycle, then drive 0,1,0,0,1,0,1 on the following cycles → payload_out=8'hA5 with valid high for 1 cycle, 8 edges after the sync edge; frame_count=1.
3. During CAPTURE of 8'h5B, pulse sync_detected at bit 5 → pulse ignored, payload_out=8'h5B. Then sync in the cycle right after the last bit, followed by 8'h3C → second word 8'h3C, frame_count=2.
4. ready=0 held; capture 8'h11 then 8'h22 → payload_out stays 8'h11, valid=1, overrun=1, frame_count=1. Then clear_overrun=1 for 1 cycle → overrun=0.
5. valid=1 holding 8'h11, ready=1 on the exact last-bit edge of 8'h77 → payload_out=8'h77, valid stays 1, overrun=0, frame_count=2.
6. Drop enable at bit 3 of a capture → busy=0 next cycle, no valid, count unchanged. Assert reset mid-capture → all outputs at reset values.
